regfile_dump: RTL
=================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter DSIZE, default 16, register data width; SHALL match the register file's data width.
REQ-002 Parameter NREG, default 16, number of registers swept; RSIZE SHALL be a local constant of 4.
REQ-003 clk  in  1  single clock; all state SHALL change on posedge clk only, except on reset.
REQ-004 rst  in  1  asynchronous, active-low reset; assertion SHALL immediately force the reset state.
REQ-005 start  in  1  sweep request; sampled only in IDLE.
REQ-006 abort  in  1  sweep cancel; sampled in READ and DRAIN.
REQ-007 first_addr  in  RSIZE  first register of the sweep; latched at start.
REQ-008 last_addr  in  RSIZE  last register of the sweep; latched at start.
REQ-009 raddr  out  RSIZE  drives one register file read address port.
REQ-010 rdata  in  DSIZE  combinational read data returned for raddr, write bypass already applied.
REQ-011 out_valid  out  1  out_addr/out_data hold a captured register.
REQ-012 out_ready  in  1  consumer accepts the entry when out_valid && out_ready at posedge.
REQ-013 out_addr  out  RSIZE  register index of the captured entry.
REQ-014 out_data  out  DSIZE  captured register value.
REQ-015 busy  out  1  high in READ and DRAIN.
REQ-016 done  out  1  one-cycle pulse when a sweep completes normally.

Function
REQ-017 FSM states SHALL be IDLE, READ, DRAIN.
REQ-018 IDLE: start=1 SHALL latch first_addr into ptr, latch last_addr into end_ptr, and go to READ; start=0 SHALL hold IDLE.
REQ-019 raddr SHALL equal ptr in READ and 0 in IDLE and DRAIN.
REQ-020 Output register is single-entry; slot_free = !out_valid || out_ready.
REQ-021 READ with slot_free: out_data <= rdata, out_addr <= ptr, out_valid <= 1; if ptr == end_ptr go to DRAIN, else ptr <= ptr + 1 modulo 16.
REQ-022 READ without slot_free: ptr, raddr, out_* SHALL hold unchanged.
REQ-023 Sweep address sequence SHALL wrap 15 -> 0; entry count = ((last_addr - first_addr) mod 16) + 1; first_addr == last_addr yields exactly one entry.
REQ-024 Throughput SHALL be one entry per cycle while out_ready is held high; first out_valid SHALL appear the cycle after start is accepted.
REQ-025 out_valid SHALL fall after acceptance only if no new entry is loaded that same cycle.
REQ-026 out_data/out_addr SHALL stay stable while out_valid && !out_ready.
REQ-027 Captured value is rdata at the capture edge; a write landing in the same cycle to ptr is therefore captured (bypass), a later write is not.
REQ-028 DRAIN: when out_valid == 0, or out_valid && out_ready, SHALL clear out_valid, pulse done for one cycle, and return to IDLE.
REQ-029 abort=1 in READ or DRAIN SHALL next cycle clear out_valid, force IDLE, and not pulse done; abort has priority over handshake progress.
REQ-030 start while busy SHALL be ignored; abort in IDLE SHALL be ignored.
REQ-031 done and start in the same cycle: done SHALL pulse and start SHALL be ignored; a new start is accepted the following cycle.

Reset
REQ-032 On rst low: state IDLE, ptr 0, end_ptr 0, raddr 0, out_valid 0, out_addr 0, out_data 0, busy 0, done 0.
REQ-033 Reset asserted mid-sweep SHALL discard the sweep with no done pulse; after release, IDLE waits for a new start.

Verification
REQ-034 Regfile r_k = 0x1000+k; start with first=0, last=15, out_ready=1 -> 16 entries addr 0..15 data 0x1000..0x100F on consecutive cycles, done 1 cycle after the last entry is accepted.
REQ-035 first=14, last=1 -> 4 entries with addr 14,15,0,1, then done.
REQ-036 first=3, last=3, out_ready low 5 cycles -> single entry addr 3 held stable 5 cycles, accepted on cycle 6, then done.
REQ-037 Same-cycle write of 0xBEEF to r5 while ptr=5 -> entry addr 5 carries 0xBEEF; a write to r5 one cycle later does not change it.
REQ-038 abort after 3 accepted entries -> out_valid 0 next cycle, no done, busy 0; start pulses issued while busy produce no extra entries.
REQ-039 rst low mid-sweep with out_valid=1 -> all outputs 0 immediately, no clock required.

Source files
------------

// File: rtl/regfile_dump.sv
// Register file sweep engine: streams a wrapping address range
// out through a single-entry valid/ready output register.
module regfile_dump #(
  parameter int DSIZE = 16,
  parameter int NREG = 16,
  localparam int RSIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [RSIZE-1:0] first_addr,
  input  logic [RSIZE-1:0] last_addr,
  output logic [RSIZE-1:0] raddr,
  input  logic [DSIZE-1:0] rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RSIZE-1:0] out_addr,
  output logic [DSIZE-1:0] out_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [RSIZE-1:0] ptr;
  logic [RSIZE-1:0] end_ptr;
  logic [RSIZE-1:0] ptr_inc;

  logic slot_free;
  logic at_end;
  logic accept_start;
  logic capture;
  logic finish;
  logic cancel;

  assign slot_free = !out_valid || out_ready;
  assign at_end    = (ptr == end_ptr);
  assign ptr_inc   = (ptr == RSIZE'(NREG - 1))
                   ? '0 : ptr + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept_start) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (capture && at_end) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cancel || finish) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A done pulse still in flight blocks a start that same cycle.
  always_comb begin
    raddr        = '0;
    busy         = 1'b0;
    accept_start = 1'b0;
    capture      = 1'b0;
    finish       = 1'b0;
    cancel       = 1'b0;
    unique case (state)
      IDLE: begin
        accept_start = start && !done;
      end
      READ: begin
        busy    = 1'b1;
        raddr   = ptr;
        cancel  = abort;
        capture = !abort && slot_free;
      end
      DRAIN: begin
        busy   = 1'b1;
        cancel = abort;
        finish = !abort && slot_free;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      end_ptr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (accept_start) begin
        ptr     <= first_addr;
        end_ptr <= last_addr;
      end
      if (capture) begin
        out_data  <= rdata;
        out_addr  <= ptr;
        out_valid <= 1'b1;
        if (!at_end) begin
          ptr <= ptr_inc;
        end
      end
      if (cancel || finish) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
